switching_activity_monitor: RTL and testbench
=============================================

// Module: switching_activity_monitor
// PURPOSE
//  Downstream of the vm test circuit. Samples its observed outputs ({out, change[1:0]}) every clock.
//  Counts per-bit toggles over a fixed window of cycles and forms a capacitance-weighted switching
//  energy estimate. Hands each window result to the accelerator's reduction stage over valid/ready.
// PARAMETERS
//  N_SIG     3   number of monitored signals (vm: {out, change[1:0]})
//  WINDOW    16  counted samples per estimation window (>=2)
//  WEIGHT_W  4   width of each per-signal weight (unsigned)
//  CNT_W     8   toggle-count result width (saturating)
//  ACC_W     16  weighted-energy result width (saturating)
// PORTS
//  clk          in   1                rising-edge clock
//  reset        in   1                asynchronous, active-low reset
//  en           in   1                monitor enable; low = IDLE
//  sig_in       in   N_SIG            monitored signal vector, sampled on clk rise
//  weights      in   N_SIG*WEIGHT_W   weight[i] = weights[i*WEIGHT_W +: WEIGHT_W]; static while en=1
//  est_valid    out  1                window result available
//  est_ready    in   1                consumer accepts result when est_valid&est_ready
//  est_toggles  out  CNT_W            total toggles in window
//  est_energy   out  ACC_W            sum of weight[i] over every toggle of bit i
//  est_sat      out  1                a result field saturated in this window
//  lost         out  1                sticky: a window result was dropped
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; est_valid, est_toggles, est_energy, est_sat, lost all 0;
//   prev sample, window counter and accumulators all 0.
//  FSM:
//   - IDLE -> PRIME when en=1.
//   - PRIME (1 cycle): latch prev<=sig_in; count nothing; -> COUNT.
//   - COUNT: per cycle, t = sig_in ^ prev; cnt += popcount(t); acc += sum weight[i] for set t[i];
//     prev<=sig_in; wcnt++.
//   - End of window: on the WINDOW-th COUNT cycle, the final totals (incl. that cycle) move to the
//     output regs. est_valid=1 from the next cycle. Accumulators and wcnt clear in the same cycle.
//   - Counting continues seamlessly, with no PRIME between windows.
//   - en=0 in any state -> IDLE next cycle: partial window discarded, accumulators cleared.
//     The output regs and est_valid are kept until handshake.
//  Arithmetic: cnt/acc saturate at all-ones, never wrap. Saturation sets a window sat flag that is
//   copied to est_sat with the result.
//  Handshake: est_valid&est_ready -> est_valid drops next cycle. Outputs stay stable while
//   est_valid=1 && !est_ready.
//  Boundaries:
//   - Window end while est_valid=1 and no handshake that cycle: new result dropped, lost<=1.
//     lost clears only on reset.
//   - Window end in the same cycle as a handshake: new result loaded, est_valid stays 1.
//   - Reset mid-window: everything cleared asynchronously; the first window after release needs
//     PRIME again.
//  Latency: est_valid rises exactly WINDOW+2 cycles after the first en=1 sample edge
//   (1 PRIME + WINDOW COUNT + 1 register).
// STRUCTURE
//  Shared package pem_pkg: state encoding (IDLE/PRIME/COUNT), default width constants.
//  Sub-module toggle_weight_sum (combinational): takes sig_in, prev and weights.
//   Outputs popcount and weighted sum for one cycle.
//  Top holds the FSM, window counter, saturating accumulators and output/handshake regs.
// TESTING (N_SIG=3, WINDOW=4, weights {w2,w1,w0}={3,2,1}, est_ready=1 unless noted)
//  1. reset=0 mid-window with est_valid=1 -> all outputs 0 immediately, before any clk edge.
//  2. sig_in held 3'b000 -> est_valid at cycle 6; est_toggles=0, est_energy=0, est_sat=0.
//  3. bit0 toggles every cycle -> est_toggles=4, est_energy=4.
//     Second window gives the same, with no PRIME gap.
//  4. all bits toggle every cycle -> est_toggles=12, est_energy=24.
//  5. est_ready=0 across two windows -> first result held stable; lost=1 after the 2nd window end;
//     raising est_ready then delivers the first result.
//  6. CNT_W=3 with all bits toggling -> est_toggles=7, est_sat=1.
//     en dropped mid-window -> no result, accumulators restart from 0.

Source files
------------

// File: rtl/pem_pkg.sv
// Shared definitions for the switching-activity monitor: FSM state encoding
// and default width constants.
package pem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_COUNT = 2'd2
    } pem_state_t;

    localparam int DEF_N_SIG    = 3;
    localparam int DEF_WINDOW   = 16;
    localparam int DEF_WEIGHT_W = 4;
    localparam int DEF_CNT_W    = 8;
    localparam int DEF_ACC_W    = 16;

    // Bits needed to hold a count in the range 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/toggle_weight_sum.sv
// Per-cycle toggle detector: number of bits that changed since the previous
// sample and the sum of the weights attached to those bits.
module toggle_weight_sum
    import pem_pkg::*;
#(
    parameter int N_SIG    = DEF_N_SIG,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int POP_W    = count_width(DEF_N_SIG),
    parameter int SUM_W    = DEF_WEIGHT_W + count_width(DEF_N_SIG)
) (
    input  logic [N_SIG-1:0]          i_sig,
    input  logic [N_SIG-1:0]          i_prev,
    input  logic [N_SIG*WEIGHT_W-1:0] i_weights,
    output logic [POP_W-1:0]          o_pop,
    output logic [SUM_W-1:0]          o_wsum
);

    logic [N_SIG-1:0] w_toggle;

    always_comb begin
        w_toggle = i_sig ^ i_prev;
        o_pop    = '0;
        o_wsum   = '0;
        for (int i = 0; i < N_SIG; i++) begin
            if (w_toggle[i]) begin
                o_pop  = o_pop + POP_W'(1);
                o_wsum = o_wsum + SUM_W'(i_weights[i*WEIGHT_W +: WEIGHT_W]);
            end
        end
    end

endmodule

// File: rtl/switching_activity_monitor.sv
// Counts per-bit toggles of the monitored vector over fixed windows and hands
// a weighted switching-energy estimate per window to the consumer over valid/ready.
module switching_activity_monitor
    import pem_pkg::*;
#(
    parameter int N_SIG    = DEF_N_SIG,
    parameter int WINDOW   = DEF_WINDOW,
    parameter int WEIGHT_W = DEF_WEIGHT_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int ACC_W    = DEF_ACC_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [N_SIG-1:0]          sig_in,
    input  logic [N_SIG*WEIGHT_W-1:0] weights,
    output logic                      est_valid,
    input  logic                      est_ready,
    output logic [CNT_W-1:0]          est_toggles,
    output logic [ACC_W-1:0]          est_energy,
    output logic                      est_sat,
    output logic                      lost
);

    localparam int POP_W = count_width(N_SIG);
    localparam int SUM_W = WEIGHT_W + POP_W;
    localparam int WC_W  = $clog2(WINDOW);
    localparam int CW    = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam int AW    = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    pem_state_t       r_state;
    pem_state_t       w_next_state;
    logic [N_SIG-1:0] r_prev;
    logic [WC_W-1:0]  r_wcnt;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_win_sat;
    logic             r_est_valid;
    logic [CNT_W-1:0] r_est_toggles;
    logic [ACC_W-1:0] r_est_energy;
    logic             r_est_sat;
    logic             r_lost;

    logic [POP_W-1:0] w_pop;
    logic [SUM_W-1:0] w_wsum;
    logic [CNT_W:0]   w_cnt_next;
    logic [ACC_W:0]   w_acc_next;
    logic             w_counting;
    logic             w_win_end;
    logic             w_win_sat;

    // Result is {saturated, value}; sums are formed one bit wider than either operand.
    function automatic logic [CNT_W:0] sat_add_cnt(input logic [CNT_W-1:0] a,
                                                   input logic [POP_W-1:0] b);
        logic [CW-1:0] s;
        s = CW'(a) + CW'(b);
        if (s > CW'({CNT_W{1'b1}}))
            return {1'b1, {CNT_W{1'b1}}};
        return {1'b0, s[CNT_W-1:0]};
    endfunction

    function automatic logic [ACC_W:0] sat_add_acc(input logic [ACC_W-1:0] a,
                                                   input logic [SUM_W-1:0] b);
        logic [AW-1:0] s;
        s = AW'(a) + AW'(b);
        if (s > AW'({ACC_W{1'b1}}))
            return {1'b1, {ACC_W{1'b1}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    toggle_weight_sum #(
        .N_SIG    (N_SIG),
        .WEIGHT_W (WEIGHT_W),
        .POP_W    (POP_W),
        .SUM_W    (SUM_W)
    ) u_tws (
        .i_sig     (sig_in),
        .i_prev    (r_prev),
        .i_weights (weights),
        .o_pop     (w_pop),
        .o_wsum    (w_wsum)
    );

    assign w_cnt_next = sat_add_cnt(r_cnt, w_pop);
    assign w_acc_next = sat_add_acc(r_acc, w_wsum);
    assign w_counting = (r_state == ST_COUNT) && en;
    assign w_win_end  = w_counting && (r_wcnt == WC_W'(WINDOW - 1));
    assign w_win_sat  = r_win_sat | w_cnt_next[CNT_W] | w_acc_next[ACC_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (!en) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_PRIME;
                ST_PRIME: w_next_state = ST_COUNT;
                ST_COUNT: w_next_state = ST_COUNT;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev    <= '0;
            r_wcnt    <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_win_sat <= 1'b0;
        end else begin
            if (en && (r_state != ST_IDLE))
                r_prev <= sig_in;
            // The window's last cycle hands its totals to the output regs, so clear here.
            if (!w_counting || w_win_end) begin
                r_wcnt    <= '0;
                r_cnt     <= '0;
                r_acc     <= '0;
                r_win_sat <= 1'b0;
            end else begin
                r_wcnt    <= r_wcnt + WC_W'(1);
                r_cnt     <= w_cnt_next[CNT_W-1:0];
                r_acc     <= w_acc_next[ACC_W-1:0];
                r_win_sat <= w_win_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_est_valid   <= 1'b0;
            r_est_toggles <= '0;
            r_est_energy  <= '0;
            r_est_sat     <= 1'b0;
            r_lost        <= 1'b0;
        end else if (w_win_end) begin
            if (!r_est_valid || est_ready) begin
                r_est_valid   <= 1'b1;
                r_est_toggles <= w_cnt_next[CNT_W-1:0];
                r_est_energy  <= w_acc_next[ACC_W-1:0];
                r_est_sat     <= w_win_sat;
            end else begin
                r_lost <= 1'b1;
            end
        end else if (r_est_valid && est_ready) begin
            r_est_valid <= 1'b0;
        end
    end

    assign est_valid   = r_est_valid;
    assign est_toggles = r_est_toggles;
    assign est_energy  = r_est_energy;
    assign est_sat     = r_est_sat;
    assign lost        = r_lost;

endmodule

// File: tb/tb_switching_activity_monitor.sv
// Directed bench for switching_activity_monitor with a queue-based scoreboard
// per instance (default widths, and a narrow CNT_W=3 variant for saturation).
module tb_switching_activity_monitor;

    localparam int N_SIG    = 3;
    localparam int WINDOW   = 4;
    localparam int WEIGHT_W = 4;

    typedef struct {
        int tog;
        int nrg;
        int sat;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [N_SIG*WEIGHT_W-1:0] weights = {4'd3, 4'd2, 4'd1};

    logic             en, est_ready, est_valid, est_sat, lost;
    logic [N_SIG-1:0] sig_in;
    logic [7:0]       est_toggles;
    logic [15:0]      est_energy;

    logic             en3, ready3, valid3, sat3, lost3;
    logic [N_SIG-1:0] sig3;
    logic [2:0]       tog3;
    logic [15:0]      nrg3;

    exp_t q_main[$];
    exp_t q_c3[$];
    int   n_checks = 0;
    int   n_errors = 0;

    switching_activity_monitor #(
        .N_SIG(N_SIG), .WINDOW(WINDOW), .WEIGHT_W(WEIGHT_W), .CNT_W(8), .ACC_W(16)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sig_in(sig_in), .weights(weights),
        .est_valid(est_valid), .est_ready(est_ready), .est_toggles(est_toggles),
        .est_energy(est_energy), .est_sat(est_sat), .lost(lost)
    );

    switching_activity_monitor #(
        .N_SIG(N_SIG), .WINDOW(WINDOW), .WEIGHT_W(WEIGHT_W), .CNT_W(3), .ACC_W(16)
    ) dut3 (
        .clk(clk), .reset(reset), .en(en3), .sig_in(sig3), .weights(weights),
        .est_valid(valid3), .est_ready(ready3), .est_toggles(tog3),
        .est_energy(nrg3), .est_sat(sat3), .lost(lost3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: a result is consumed on each cycle with valid & ready.
    always @(negedge clk) begin
        if (reset && est_valid && est_ready) begin
            n_checks++;
            if (q_main.size() == 0) begin
                n_errors++;
                $display("FAIL main_unexpected: got tog=%0d nrg=%0d, expected no result",
                         est_toggles, est_energy);
            end else begin
                exp_t e;
                e = q_main.pop_front();
                if (est_toggles != e.tog || est_energy != e.nrg || est_sat != e.sat) begin
                    n_errors++;
                    $display("FAIL main_result: got tog=%0d nrg=%0d sat=%0d, expected tog=%0d nrg=%0d sat=%0d",
                             est_toggles, est_energy, est_sat, e.tog, e.nrg, e.sat);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && valid3 && ready3) begin
            n_checks++;
            if (q_c3.size() == 0) begin
                n_errors++;
                $display("FAIL c3_unexpected: got tog=%0d nrg=%0d, expected no result", tog3, nrg3);
            end else begin
                exp_t e;
                e = q_c3.pop_front();
                if (tog3 != e.tog || nrg3 != e.nrg || sat3 != e.sat) begin
                    n_errors++;
                    $display("FAIL c3_result: got tog=%0d nrg=%0d sat=%0d, expected tog=%0d nrg=%0d sat=%0d",
                             tog3, nrg3, sat3, e.tog, e.nrg, e.sat);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; en = 1'b0; sig_in = '0; est_ready = 1'b1;
        en3 = 1'b0; sig3 = '0; ready3 = 1'b1;
        tick(2);
        chk("reset_valid", est_valid, 0);
        chk("reset_lost", lost, 0);
        reset = 1'b1;
        tick(2);

        // Quiet input: latency to first result and an all-zero estimate.
        q_main.push_back('{0, 0, 0});
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk($sformatf("latency_c%0d", k), est_valid, (k == 6) ? 1 : 0);
        end
        en = 1'b0;
        tick(2);

        // bit0 toggling: two back-to-back windows, no PRIME in between.
        q_main.push_back('{4, 4, 0});
        q_main.push_back('{4, 4, 0});
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            sig_in = sig_in ^ 3'b001;
        end
        chk("seamless_valid", est_valid, 1);
        en = 1'b0;
        tick(2);

        // All bits toggling.
        q_main.push_back('{12, 24, 0});
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            sig_in = sig_in ^ 3'b111;
        end
        en = 1'b0;
        tick(2);

        // Backpressure across two windows: first held, second dropped.
        est_ready = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            sig_in = sig_in ^ ((k <= 5) ? 3'b111 : 3'b001);
            if (k == 8) begin
                chk("hold_toggles", est_toggles, 12);
                chk("hold_lost", lost, 0);
            end
        end
        chk("bp_valid", est_valid, 1);
        chk("bp_toggles", est_toggles, 12);
        chk("bp_energy", est_energy, 24);
        chk("bp_lost", lost, 1);
        en = 1'b0;
        q_main.push_back('{12, 24, 0});
        est_ready = 1'b1;
        tick(2);
        chk("bp_drain_valid", est_valid, 0);
        chk("lost_sticky", lost, 1);

        // Asynchronous reset while a result is pending.
        est_ready = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            sig_in = sig_in ^ 3'b111;
        end
        chk("pre_reset_valid", est_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", est_valid, 0);
        chk("arst_toggles", est_toggles, 0);
        chk("arst_energy", est_energy, 0);
        chk("arst_sat", est_sat, 0);
        chk("arst_lost", lost, 0);
        en = 1'b0;
        est_ready = 1'b1;
        sig_in = '0;
        tick(1);
        reset = 1'b1;

        // After reset release the first window needs PRIME again.
        q_main.push_back('{0, 0, 0});
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            chk($sformatf("post_reset_c%0d", k), est_valid, (k == 6) ? 1 : 0);
        end
        en = 1'b0;
        tick(2);

        // Narrow counter saturates; then en drop mid-window discards the partial window.
        q_c3.push_back('{7, 24, 1});
        en3 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            sig3 = sig3 ^ 3'b111;
            if (k == 6) chk("c3_valid", valid3, 1);
        end
        en3 = 1'b0;
        tick(2);
        q_c3.push_back('{4, 4, 0});
        en3 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            sig3 = sig3 ^ 3'b001;
        end
        en3 = 1'b0;
        tick(3);

        chk("main_queue_drained", q_main.size(), 0);
        chk("c3_queue_drained", q_c3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
